// File: rtl/delta_sigma_mod2.sv
// delta_sigma_mod2: 2nd-order 1-bit delta-sigma modulator with overload recovery.
// Define DSM_DITHER_EN to add 16-bit LFSR dither in front of the quantizer.
module delta_sigma_mod2 #(
  parameter int INT_W       = 24,
  parameter int OVL_LIMIT   = 64,
  parameter int QUIET_CYC   = 16,
  parameter int RECOVER_CYC = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_i,
  input  logic [19:0] mix_i,
  input  logic        clr_ovl_i,
  output logic        bit_o,
  output logic        ovl_o,
  output logic        recov_o
);

  localparam int SW = INT_W + 2;
  localparam int CW = $clog2(OVL_LIMIT + 1);
  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam int RW = $clog2(RECOVER_CYC + 1);

  localparam logic signed [SW-1:0] FS =
    {{(SW-20){1'b0}}, 20'h80000};
  localparam logic signed [SW-1:0] NFS =
    {{(SW-20){1'b1}}, 20'h80000};
  localparam logic signed [SW-1:0] MAXV =
    {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {3'b111, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] MAXI =
    {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MINI =
    {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic {
    RUN,
    RECOVER
  } st_e;

  st_e st_q, st_d;

  logic [INT_W-1:0] i1, i2;
  logic [INT_W-1:0] i1_d, i2_d;
  logic [CW-1:0]    sat_cnt, sat_d;
  logic [QW-1:0]    q_cnt, q_d;
  logic [RW-1:0]    rc, rc_d;
  logic             bit_d, ovl_d;

  logic signed [SW-1:0] dith;

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'hACE1;
    end else if (en_i) begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign dith = {{(SW-4){lfsr[3]}}, lfsr[3:0]};
`else
  assign dith = '0;
`endif

  logic signed [SW-1:0] x, fb, i1_w, i2_w;
  logic signed [SW-1:0] qs, e1, e2, s1, s2;
  logic y, hi1, lo1, hi2, lo2, ev;

  always_comb begin
    x    = {{(SW-20){mix_i[19]}}, mix_i};
    i1_w = {{2{i1[INT_W-1]}}, i1};
    i2_w = {{2{i2[INT_W-1]}}, i2};
    qs   = i2_w + dith;
    y    = (qs >= 0);
    fb   = y ? FS : NFS;
    e1   = (x - fb) >>> 1;
    e2   = (i1_w - fb) >>> 1;
    s1   = i1_w + e1;
    s2   = i2_w + e2;
    hi1  = (s1 > MAXV);
    lo1  = (s1 < MINV);
    hi2  = (s2 > MAXV);
    lo2  = (s2 < MINV);
    ev   = hi1 | lo1 | hi2 | lo2;
  end

  always_comb begin
    st_d  = st_q;
    i1_d  = i1;
    i2_d  = i2;
    sat_d = sat_cnt;
    q_d   = q_cnt;
    rc_d  = rc;
    bit_d = bit_o;
    ovl_d = ovl_o;
    if (en_i) begin
      if (clr_ovl_i) ovl_d = 1'b0;
      unique case (1'b1)
        (st_q == RUN): begin
          bit_d = y;
          if (ev && sat_cnt == CW'(OVL_LIMIT - 1)) begin
            st_d  = RECOVER;
            i1_d  = '0;
            i2_d  = '0;
            sat_d = '0;
            q_d   = '0;
            rc_d  = '0;
            ovl_d = 1'b1;
          end else begin
            i1_d = hi1 ? MAXI : lo1 ? MINI : s1[INT_W-1:0];
            i2_d = hi2 ? MAXI : lo2 ? MINI : s2[INT_W-1:0];
            // a quiet run of QUIET_CYC cycles forgets old events
            if (ev) begin
              sat_d = sat_cnt + CW'(1);
              q_d   = '0;
            end else if (q_cnt == QW'(QUIET_CYC - 1)) begin
              sat_d = '0;
              q_d   = '0;
            end else begin
              q_d = q_cnt + QW'(1);
            end
          end
        end
        (st_q == RECOVER): begin
          i1_d = '0;
          i2_d = '0;
          if (rc == RW'(RECOVER_CYC)) begin
            st_d = RUN;
            rc_d = '0;
          end else begin
            bit_d = ~rc[0];
            rc_d  = rc + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q    <= RUN;
      i1      <= '0;
      i2      <= '0;
      sat_cnt <= '0;
      q_cnt   <= '0;
      rc      <= '0;
      bit_o   <= 1'b0;
      ovl_o   <= 1'b0;
    end else begin
      st_q    <= st_d;
      i1      <= i1_d;
      i2      <= i2_d;
      sat_cnt <= sat_d;
      q_cnt   <= q_d;
      rc      <= rc_d;
      bit_o   <= bit_d;
      ovl_o   <= ovl_d;
    end
  end

  assign recov_o = (st_q == RECOVER);

endmodule
